delay_mem_scheduler: RTL and testbench
======================================

// Module: delay_mem_scheduler
// PURPOSE
//  Time-division scheduler for one shared single-port delay-line RAM used by the effect chain (octaver, echo, ...).
//  On every audio_ready sample strobe it runs one frame:
//   - one write slot stores the new sample at the write pointer;
//   - then one read slot per requester returns the sample that is rd_offset samples old.
//  It owns the circular write pointer and its wrap at max_delay. Effects therefore only supply delay offsets and never drive RAM addresses.
// PARAMETERS
//  DATA_WIDTH  32  sample / RAM word width
//  ADDR_WIDTH  13  RAM address width (depth 2**ADDR_WIDTH)
//  NUM_REQ     2   number of read requesters (1..8)
// PORTS
//  CLK          in   1                     clock
//  rst          in   1                     asynchronous reset, active-low
//  audio_ready  in   1                     one-cycle sample strobe
//  x            in   DATA_WIDTH            input sample, valid with audio_ready
//  max_delay    in   ADDR_WIDTH            last valid RAM address (ring length - 1)
//  req          in   NUM_REQ               per-requester read enable
//  rd_offset    in   NUM_REQ*ADDR_WIDTH    per-requester delay in samples; slice k = [k*AW +: AW]
//  clr_overrun  in   1                     clears overrun flag
//  mem_we       out  1                     RAM write enable (registered)
//  mem_addr     out  ADDR_WIDTH            RAM address (registered)
//  mem_di       out  DATA_WIDTH            RAM write data (registered)
//  mem_do       in   DATA_WIDTH            RAM read data, valid one cycle after the read address edge
//  rd_data      out  DATA_WIDTH            returned sample (registered)
//  rd_valid     out  NUM_REQ               one-hot, one-cycle strobe qualifying rd_data
//  frame_done   out  1                     one-cycle end-of-frame pulse
//  busy         out  1                     high while a frame is in progress
//  overrun      out  1                     sticky: an audio_ready strobe was dropped
// BEHAVIOUR
//  Reset values:
//   - all outputs 0;
//   - wr_ptr = 0, pending = 0, state = IDLE.
//  States: IDLE -> WRITE -> RD0 .. RD(NUM_REQ-1) -> DRAIN -> IDLE.
//  Frame start:
//   - Trigger: audio_ready sampled high in IDLE at edge E0, or pending set on the return to IDLE.
//   - Latched at E0: x, req, rd_offset and max_delay are held for the whole frame.
//  WRITE (after E0):
//   - mem_we = 1, mem_addr = wr_ptr, mem_di = x.
//  RDk (after edge E(k+1)):
//   - mem_we = 0, mem_addr = raddr_k.
//   - Offset clamp: off = min(rd_offset_k, max_delay).
//   - Address: raddr_k = wr_ptr - off if off <= wr_ptr, else wr_ptr + max_delay + 1 - off.
//   - off = 0 returns the sample written in this frame (write precedes read).
//   - If req[k] = 0, the slot is still consumed (fixed frame length), and rd_valid[k] is not asserted.
//  Read return:
//   - mem_do for slot k is registered into rd_data at edge E(k+3), with rd_valid[k] high for that cycle.
//   - rd_data holds its value between strobes.
//  DRAIN / frame end:
//   - mem_addr is held; mem_we = 0.
//   - At edge E(NUM_REQ+2), frame_done pulses (coincident with the last slot's rd_valid).
//   - At the same edge, wr_ptr <= (wr_ptr >= max_delay) ? 0 : wr_ptr+1, and state returns to IDLE.
//   - Shrinking max_delay below wr_ptr therefore wraps to 0 at the next advance.
//   - Frame length is NUM_REQ+3 cycles, so the minimum audio_ready spacing without queuing is NUM_REQ+3.
//  busy:
//   - Registered; high from E0 through the edge that asserts frame_done; low from the cycle after frame_done.
//  audio_ready while busy:
//   - If pending = 0: set pending and capture x into a pending buffer.
//   - If pending = 1: drop the sample and set overrun.
//   - A pending frame starts at the first edge in IDLE; one IDLE cycle separates the frames.
//  overrun:
//   - Cleared only by clr_overrun or reset.
//   - When clr_overrun and a new drop occur in the same cycle, set wins.
//  Reset mid-frame: abort immediately, no RAM write completes after reset asserts, and all state returns to reset values.
// TESTING
//  1. Reset, max_delay=15, NUM_REQ=2, req=11, offsets 0/3; strobe x=0x11 -> mem_we at 0x0 (one cycle); rd_valid[0]: rd_data=0x11; frame_done at NUM_REQ+2 edges after the strobe.
//  2. 20 strobes, x=n, max_delay=15 -> wr_ptr wraps 15->0; offset 3 at wr_ptr=1 reads addr 14, returns the value written 3 frames earlier.
//  3. req=01 -> only rd_valid[0] pulses, frame still NUM_REQ+3 cycles; rd_offset=40 with max_delay=15 -> clamped to 15.
//  4. Strobe 2 cycles after a frame start -> pending, second frame follows with its x; a third strobe in the same frame -> dropped, overrun=1 until clr_overrun.
//  5. max_delay lowered 15->4 while wr_ptr=9 -> next advance sets wr_ptr=0; subsequent reads wrap at 4.
//  6. rst low during RD0 -> all outputs 0 next cycle, mem_we=0, wr_ptr=0; the next strobe writes address 0.

Source files
------------

// File: rtl/delay_mem_scheduler_if.sv
// Bus bundle between the delay-line scheduler, its effect requesters and the shared RAM.
interface delay_mem_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_REQ    = 2
);
    logic                          audio_ready;
    logic [DATA_WIDTH-1:0]         x;
    logic [ADDR_WIDTH-1:0]         max_delay;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rd_offset;
    logic                          clr_overrun;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_di;
    logic [DATA_WIDTH-1:0]         mem_do;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic [NUM_REQ-1:0]            rd_valid;
    logic                          frame_done;
    logic                          busy;
    logic                          overrun;

    modport slave (
        input  audio_ready, x, max_delay, req, rd_offset, clr_overrun, mem_do,
        output mem_we, mem_addr, mem_di, rd_data, rd_valid, frame_done, busy, overrun
    );

    modport master (
        output audio_ready, x, max_delay, req, rd_offset, clr_overrun, mem_do,
        input  mem_we, mem_addr, mem_di, rd_data, rd_valid, frame_done, busy, overrun
    );
endinterface

// File: rtl/delay_mem_scheduler.sv
// Time-division scheduler for the shared single-port delay-line RAM.
// One frame per sample strobe: a write slot, then one read slot per requester.
//
//   state | meaning
//   IDLE  | waiting for a strobe or a pending sample
//   WRITE | new sample driven to RAM at wr_ptr
//   RD    | read slot 'slot' address driven to RAM
//   DRAIN | last read data in flight; frame closes, wr_ptr advances
module delay_mem_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_REQ    = 2
) (
    input logic                 CLK,
    input logic                 rst,
    delay_mem_scheduler_if.slave bus
);
    localparam int              SW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SW-1:0]   LAST = SW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WRITE, RD, DRAIN} state_t;

    state_t                        state, state_nxt;
    logic [SW-1:0]                 slot, slot_nxt;
    logic [ADDR_WIDTH-1:0]         wr_ptr, wr_ptr_nxt;
    logic                          pending, pending_nxt;
    logic [DATA_WIDTH-1:0]         pend_x, pend_x_nxt;
    logic [NUM_REQ-1:0]            req_l;
    logic [NUM_REQ*ADDR_WIDTH-1:0] off_l;
    logic [ADDR_WIDTH-1:0]         max_l;
    logic                          p1_v, p1_v_nxt, p2_v;
    logic [SW-1:0]                 p1_idx, p2_idx;
    logic                          start, drop;
    logic [DATA_WIDTH-1:0]         frame_x;
    logic [ADDR_WIDTH-1:0]         off_raw, off, raddr;

    logic                          mem_we_q, mem_we_nxt;
    logic [ADDR_WIDTH-1:0]         mem_addr_q, mem_addr_nxt;
    logic [DATA_WIDTH-1:0]         mem_di_q, mem_di_nxt;
    logic [DATA_WIDTH-1:0]         rd_data_q, rd_data_nxt;
    logic [NUM_REQ-1:0]            rd_valid_q, rd_valid_nxt;
    logic                          frame_done_q, frame_done_nxt;
    logic                          busy_q, busy_nxt;
    logic                          overrun_q, overrun_nxt;

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_di     = mem_di_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

    // Next-state, slot address generation, strobe queuing and registered-output values.
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        start       = 1'b0;
        pending_nxt = pending;
        pend_x_nxt  = pend_x;
        drop        = 1'b0;
        frame_x     = pending ? pend_x : bus.x;

        case (state)
            IDLE: begin
                if (pending || bus.audio_ready) begin
                    start     = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = RD;
                slot_nxt  = '0;
            end
            RD: begin
                if (slot == LAST) state_nxt = DRAIN;
                else              slot_nxt  = slot + SW'(1);
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A pending sample is consumed on the start edge; a strobe arriving on that
        // same edge refills the buffer instead of being lost.
        if (state == IDLE) begin
            if (pending) begin
                pending_nxt = bus.audio_ready;
                if (bus.audio_ready) pend_x_nxt = bus.x;
            end
        end else if (bus.audio_ready) begin
            if (!pending) begin
                pending_nxt = 1'b1;
                pend_x_nxt  = bus.x;
            end else begin
                drop = 1'b1;
            end
        end
        overrun_nxt = drop ? 1'b1 : (bus.clr_overrun ? 1'b0 : overrun_q);

        off_raw = off_l[slot_nxt*ADDR_WIDTH +: ADDR_WIDTH];
        off     = (off_raw > max_l) ? max_l : off_raw;
        raddr   = (off <= wr_ptr) ? (wr_ptr - off)
                                  : (wr_ptr + max_l + ADDR_WIDTH'(1) - off);

        mem_we_nxt     = start;
        mem_addr_nxt   = start ? wr_ptr : ((state_nxt == RD) ? raddr : mem_addr_q);
        mem_di_nxt     = start ? frame_x : mem_di_q;
        p1_v_nxt       = (state_nxt == RD) && req_l[slot_nxt];
        frame_done_nxt = (state == DRAIN);
        busy_nxt       = (state_nxt != IDLE) || (state == DRAIN);
        wr_ptr_nxt     = wr_ptr;
        if (state == DRAIN) wr_ptr_nxt = (wr_ptr >= max_l) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        rd_valid_nxt   = p2_v ? (NUM_REQ'(1) << p2_idx) : '0;
        rd_data_nxt    = p2_v ? bus.mem_do : rd_data_q;
    end

    // State, frame configuration latch, read-return pipeline and output registers.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            slot         <= '0;
            wr_ptr       <= '0;
            pending      <= 1'b0;
            pend_x       <= '0;
            req_l        <= '0;
            off_l        <= '0;
            max_l        <= '0;
            p1_v         <= 1'b0;
            p1_idx       <= '0;
            p2_v         <= 1'b0;
            p2_idx       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_di_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            slot         <= slot_nxt;
            wr_ptr       <= wr_ptr_nxt;
            pending      <= pending_nxt;
            pend_x       <= pend_x_nxt;
            if (start) begin
                req_l <= bus.req;
                off_l <= bus.rd_offset;
                max_l <= bus.max_delay;
            end
            p1_v         <= p1_v_nxt;
            p1_idx       <= slot_nxt;
            p2_v         <= p1_v;
            p2_idx       <= p1_idx;
            mem_we_q     <= mem_we_nxt;
            mem_addr_q   <= mem_addr_nxt;
            mem_di_q     <= mem_di_nxt;
            rd_data_q    <= rd_data_nxt;
            rd_valid_q   <= rd_valid_nxt;
            frame_done_q <= frame_done_nxt;
            busy_q       <= busy_nxt;
            overrun_q    <= overrun_nxt;
        end
    end
endmodule

// File: tb/tb_delay_mem_scheduler.sv
// Directed bench for delay_mem_scheduler with a RAM model and a read-return scoreboard.
module tb_delay_mem_scheduler;
    localparam int DW = 32;
    localparam int AW = 13;
    localparam int NR = 2;

    logic CLK;
    logic rst;

    delay_mem_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    delay_mem_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram     [0:8191] = '{default: '0};
    logic [31:0] mdl_mem [0:8191] = '{default: '0};
    logic [12:0] mdl_ptr = '0;
    int          checks   = 0;
    int          failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous single-port RAM, read data one cycle after the address edge.
    always @(posedge CLK) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_di;
        bus.mem_do <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [12:0] exp_raddr(input logic [12:0] o, input logic [12:0] md);
        logic [12:0] of;
        of = (o > md) ? md : o;
        return (of <= mdl_ptr) ? mdl_ptr - of : mdl_ptr + md + 13'd1 - of;
    endfunction

    task automatic model_frame(input logic [31:0] xv, input logic [1:0] rq,
                               input logic [12:0] o0, input logic [12:0] o1, input logic [12:0] md,
                               output logic [12:0] wa, output logic [12:0] ra0, output logic [12:0] ra1);
        wa = mdl_ptr;
        mdl_mem[mdl_ptr] = xv;
        ra0 = exp_raddr(o0, md);
        ra1 = exp_raddr(o1, md);
        if (rq[0]) sb.push_back('{0, mdl_mem[ra0]});
        if (rq[1]) sb.push_back('{1, mdl_mem[ra1]});
        mdl_ptr = (mdl_ptr >= md) ? 13'd0 : mdl_ptr + 13'd1;
    endtask

    task automatic run_frame(input logic [31:0] xv, input logic [1:0] rq,
                             input logic [12:0] o0, input logic [12:0] o1, input logic [12:0] md);
        logic [12:0] wa, ra0, ra1;
        bus.x = xv;
        bus.req = rq;
        bus.rd_offset = {o1, o0};
        bus.max_delay = md;
        bus.audio_ready = 1'b1;
        model_frame(xv, rq, o0, o1, md, wa, ra0, ra1);
        tick();
        bus.audio_ready = 1'b0;
        chk("wr_we", bus.mem_we, 1);
        chk("wr_addr", bus.mem_addr, wa);
        chk("wr_di", bus.mem_di, xv);
        chk("busy_start", bus.busy, 1);
        tick();
        chk("rd0_we", bus.mem_we, 0);
        chk("rd0_addr", bus.mem_addr, ra0);
        if (wa == 13'd1 && o1 == 13'd3 && md == 13'd15) chk("rd1_wrap_addr14", ra1, 13'd14);
        tick();
        chk("rd1_addr", bus.mem_addr, ra1);
        tick();
        chk("slot0_valid", bus.rd_valid, {1'b0, rq[0]});
        chk("drain_no_done", bus.frame_done, 0);
        tick();
        chk("slot1_valid", bus.rd_valid, {rq[1], 1'b0});
        chk("frame_done", bus.frame_done, 1);
        chk("busy_end", bus.busy, 1);
        tick();
        chk("frame_done_clr", bus.frame_done, 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    // Scoreboard: every rd_valid strobe must match the oldest expected read return.
    always @(negedge CLK) begin
        if (rst && bus.rd_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", bus.rd_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rd_valid", bus.rd_valid, 2'b01 << e.idx);
                chk("sb_rd_data", bus.rd_data, e.data);
            end
        end
    end

    initial begin
        logic [12:0] wa, ra0, ra1;
        rst = 1'b0;
        bus.audio_ready = 1'b0;
        bus.x = '0;
        bus.max_delay = 13'd15;
        bus.req = 2'b11;
        bus.rd_offset = '0;
        bus.clr_overrun = 1'b0;
        tick(); tick(); tick();
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_di", bus.mem_di, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b1;
        tick();

        // basic frame, offset 0 returns the sample just written
        run_frame(32'h11, 2'b11, 13'd0, 13'd3, 13'd15);

        // ring wrap at max_delay
        for (int n = 0; n < 20; n++)
            run_frame(32'h1000 + n, 2'b11, 13'd0, 13'd3, 13'd15);

        // masked requester and offset clamp
        run_frame(32'h2001, 2'b01, 13'd2, 13'd5, 13'd15);
        run_frame(32'h2002, 2'b11, 13'd1, 13'd40, 13'd15);

        // pending strobe, then dropped strobe
        bus.req = 2'b11;
        bus.rd_offset = {13'd2, 13'd1};
        bus.max_delay = 13'd15;
        bus.x = 32'hA0A0;
        bus.audio_ready = 1'b1;
        model_frame(32'hA0A0, 2'b11, 13'd1, 13'd2, 13'd15, wa, ra0, ra1);
        tick();
        bus.audio_ready = 1'b0;
        chk("pend_a_busy", bus.busy, 1);
        tick();
        bus.x = 32'hB0B0;
        bus.audio_ready = 1'b1;
        model_frame(32'hB0B0, 2'b11, 13'd1, 13'd2, 13'd15, wa, ra0, ra1);
        tick();
        bus.x = 32'hC0C0;
        tick();
        bus.audio_ready = 1'b0;
        chk("overrun_set", bus.overrun, 1);
        tick();
        chk("pend_a_done", bus.frame_done, 1);
        tick();
        chk("pend_b_we", bus.mem_we, 1);
        chk("pend_b_addr", bus.mem_addr, wa);
        chk("pend_b_di", bus.mem_di, 32'hB0B0);
        chk("pend_b_busy", bus.busy, 1);
        chk("pend_b_done_clr", bus.frame_done, 0);
        tick(); tick(); tick(); tick();
        chk("pend_b_done", bus.frame_done, 1);
        tick();
        chk("pend_b_idle", bus.busy, 0);
        chk("overrun_sticky", bus.overrun, 1);
        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        chk("overrun_clr", bus.overrun, 0);

        // max_delay shrink below wr_ptr
        for (int i = 0; i < 16 && mdl_ptr != 13'd9; i++)
            run_frame(32'h3000 + i, 2'b11, 13'd0, 13'd3, 13'd15);
        chk("ptr_at_9", mdl_ptr, 13'd9);
        run_frame(32'h4009, 2'b11, 13'd0, 13'd3, 13'd4);
        for (int i = 0; i < 6; i++)
            run_frame(32'h5000 + i, 2'b11, 13'd1, 13'd3, 13'd4);

        // reset during RD0
        bus.x = 32'hDEAD;
        bus.req = 2'b11;
        bus.rd_offset = {13'd1, 13'd0};
        bus.max_delay = 13'd15;
        bus.audio_ready = 1'b1;
        tick();
        bus.audio_ready = 1'b0;
        mdl_mem[mdl_ptr] = 32'hDEAD;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("rrst_mem_we", bus.mem_we, 0);
        chk("rrst_mem_addr", bus.mem_addr, 0);
        chk("rrst_mem_di", bus.mem_di, 0);
        chk("rrst_rd_data", bus.rd_data, 0);
        chk("rrst_rd_valid", bus.rd_valid, 0);
        chk("rrst_busy", bus.busy, 0);
        chk("rrst_frame_done", bus.frame_done, 0);
        tick();
        chk("rrst_mem_we_next", bus.mem_we, 0);
        rst = 1'b1;
        mdl_ptr = '0;
        tick();
        run_frame(32'h77, 2'b11, 13'd0, 13'd1, 13'd15);
        tick(); tick();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
